// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the multi-warp PC sequencer.
//   warp_state_e  per-warp execution state
//   N, Z, P       bit positions inside a 3-bit {N,Z,P} flag/condition vector
//   branch_taken  BRnzp condition evaluation against a warp's NZP register
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } warp_state_e;

  localparam int N = 2;
  localparam int Z = 1;
  localparam int P = 0;

  // A branch is taken when any condition bit it tests is set in the flags.
  function automatic logic branch_taken(input logic [2:0] cond,
                                        input logic [2:0] flags);
    return (cond[N] & flags[N]) | (cond[Z] & flags[Z]) | (cond[P] & flags[P]);
  endfunction

endpackage

// File: rtl/warp_pc_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req         in  N  one request bit per requester
//   ptr         in  W  highest-priority index this cycle
//   grant_valid out 1  at least one request is set
//   grant_idx   out W  first requesting index at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);

  int unsigned idx;

  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/warp_pc_sequencer.sv
// warp_pc_sequencer: per-warp PC / NZP / state holder with round-robin issue.
//   clk, reset          clock, synchronous active-high reset
//   start, start_pc,    launch request from the dispatcher (ignored while busy)
//   warp_mask
//   busy, done          run in progress / one-cycle completion pulse
//   issue_valid/warp/pc offer of a READY warp to fetch; issue_ready accepts it
//   commit_*            retirement of an instruction of a WAIT warp
//   nzp_we/warp/value   NZP flag register write
module warp_pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int NUM_WARPS = 4,
  parameter int WARP_BITS = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_pc,
  input  logic [NUM_WARPS-1:0] warp_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 issue_valid,
  output logic [WARP_BITS-1:0] issue_warp,
  output logic [ADDR_BITS-1:0] issue_pc,
  input  logic                 issue_ready,
  input  logic                 commit_valid,
  input  logic [WARP_BITS-1:0] commit_warp,
  input  logic                 commit_branch,
  input  logic [2:0]           commit_nzp,
  input  logic [ADDR_BITS-1:0] commit_target,
  input  logic                 commit_halt,
  input  logic                 nzp_we,
  input  logic [WARP_BITS-1:0] nzp_warp,
  input  logic [2:0]           nzp_value
);

  warp_state_e          state_q [NUM_WARPS];
  warp_state_e          state_d [NUM_WARPS];
  logic [ADDR_BITS-1:0] pc_q    [NUM_WARPS];
  logic [ADDR_BITS-1:0] pc_d    [NUM_WARPS];
  logic [2:0]           nzp_q   [NUM_WARPS];
  logic [2:0]           nzp_d   [NUM_WARPS];

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WARP_BITS-1:0] rr_ptr_q, rr_ptr_d;
  // An offer that was not accepted is pinned so that a warp turning READY
  // by commit cannot displace it while fetch applies back-pressure.
  logic                 hold_valid_q, hold_valid_d;
  logic [WARP_BITS-1:0] hold_warp_q, hold_warp_d;

  logic [NUM_WARPS-1:0] ready_req;
  logic                 grant_valid;
  logic [WARP_BITS-1:0] grant_idx;
  logic                 start_accept;
  logic                 handshake;
  logic                 any_active;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) ready_req[w] = (state_q[w] == READY);
  end

  rr_arbiter #(
    .N (NUM_WARPS),
    .W (WARP_BITS)
  ) u_arb (
    .req         (ready_req),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the per-warp arrays are only NUM_WARPS entries of flops, not a
      // RAM, so they are reset like any other register.
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= IDLE;
        pc_q[w]    <= '0;
        nzp_q[w]   <= '0;
      end
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rr_ptr_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_warp_q  <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w] <= state_d[w];
        pc_q[w]    <= pc_d[w];
        nzp_q[w]   <= nzp_d[w];
      end
      busy_q       <= busy_d;
      done_q       <= done_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_valid_q <= hold_valid_d;
      hold_warp_q  <= hold_warp_d;
    end
  end

  // Next-state logic.
  always_comb begin
    start_accept = start && !busy_q;
    handshake    = issue_valid && issue_ready;
    any_active   = 1'b0;

    for (int w = 0; w < NUM_WARPS; w++) begin
      state_d[w] = state_q[w];
      pc_d[w]    = pc_q[w];
      nzp_d[w]   = nzp_q[w];

      // The cycle showing done is the last one with warps in HALTED.
      if (done_q) state_d[w] = IDLE;

      // Start is only accepted while idle, when no warp can be READY or
      // WAIT, so it never competes with issue or commit.
      if (start_accept) begin
        if (warp_mask[w]) begin
          state_d[w] = READY;
          pc_d[w]    = start_pc;
          nzp_d[w]   = '0;
        end else begin
          state_d[w] = IDLE;
        end
      end else begin
        if (handshake && issue_warp == WARP_BITS'(w)) state_d[w] = WAIT;

        if (commit_valid && commit_warp == WARP_BITS'(w) && state_q[w] == WAIT) begin
          if (commit_halt) begin
            state_d[w] = HALTED;
          end else begin
            // Uses the registered NZP, so a same-cycle flag write only
            // affects later branches.
            if (commit_branch && branch_taken(commit_nzp, nzp_q[w]))
              pc_d[w] = commit_target;
            else
              pc_d[w] = pc_q[w] + ADDR_BITS'(1);
            state_d[w] = READY;
          end
        end
      end

      if (nzp_we && nzp_warp == WARP_BITS'(w)) nzp_d[w] = nzp_value;

      if (state_d[w] == READY || state_d[w] == WAIT) any_active = 1'b1;
    end

    busy_d = busy_q;
    done_d = 1'b0;
    if (start_accept) begin
      if (warp_mask == '0) done_d = 1'b1;
      else                 busy_d = 1'b1;
    end else if (busy_q && !any_active) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end

    rr_ptr_d = rr_ptr_q;
    if (handshake)
      rr_ptr_d = (issue_warp == WARP_BITS'(NUM_WARPS - 1)) ? '0
                                                           : issue_warp + WARP_BITS'(1);

    hold_valid_d = issue_valid && !issue_ready;
    hold_warp_d  = issue_warp;
  end

  // Output logic: registered state only.
  always_comb begin
    issue_valid = hold_valid_q || grant_valid;
    issue_warp  = hold_valid_q ? hold_warp_q : grant_idx;
    issue_pc    = '0;
    for (int w = 0; w < NUM_WARPS; w++)
      if (issue_warp == WARP_BITS'(w)) issue_pc = pc_q[w];
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_warp_pc_sequencer.sv
module tb_warp_pc_sequencer;

  localparam int ADDR_BITS = 8;
  localparam int NUM_WARPS = 4;
  localparam int WARP_BITS = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [ADDR_BITS-1:0] start_pc;
  logic [NUM_WARPS-1:0] warp_mask;
  logic                 busy, done;
  logic                 issue_valid;
  logic [WARP_BITS-1:0] issue_warp;
  logic [ADDR_BITS-1:0] issue_pc;
  logic                 issue_ready;
  logic                 commit_valid;
  logic [WARP_BITS-1:0] commit_warp;
  logic                 commit_branch;
  logic [2:0]           commit_nzp;
  logic [ADDR_BITS-1:0] commit_target;
  logic                 commit_halt;
  logic                 nzp_we;
  logic [WARP_BITS-1:0] nzp_warp;
  logic [2:0]           nzp_value;

  warp_pc_sequencer #(
    .ADDR_BITS (ADDR_BITS),
    .NUM_WARPS (NUM_WARPS),
    .WARP_BITS (WARP_BITS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_pc      (start_pc),
    .warp_mask     (warp_mask),
    .busy          (busy),
    .done          (done),
    .issue_valid   (issue_valid),
    .issue_warp    (issue_warp),
    .issue_pc      (issue_pc),
    .issue_ready   (issue_ready),
    .commit_valid  (commit_valid),
    .commit_warp   (commit_warp),
    .commit_branch (commit_branch),
    .commit_nzp    (commit_nzp),
    .commit_target (commit_target),
    .commit_halt   (commit_halt),
    .nzp_we        (nzp_we),
    .nzp_warp      (nzp_warp),
    .nzp_value     (nzp_value)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WARP_BITS-1:0] warp;
    logic [ADDR_BITS-1:0] pc;
  } issue_t;

  issue_t exp_q[$];
  int     checks   = 0;
  int     errors   = 0;
  int     done_cnt = 0;
  int     done_base;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    start         = 1'b0;
    commit_valid  = 1'b0;
    commit_branch = 1'b0;
    commit_halt   = 1'b0;
    nzp_we        = 1'b0;
    issue_ready   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic expect_issue(input int w, input int pc);
    exp_q.push_back(issue_t'{warp: WARP_BITS'(w), pc: ADDR_BITS'(pc)});
  endtask

  task automatic launch(input int pc, input int mask);
    start     = 1'b1;
    start_pc  = ADDR_BITS'(pc);
    warp_mask = NUM_WARPS'(mask);
  endtask

  task automatic set_commit(input int w, input bit br, input int cond,
                            input int tgt, input bit halt);
    commit_valid  = 1'b1;
    commit_warp   = WARP_BITS'(w);
    commit_branch = br;
    commit_nzp    = 3'(cond);
    commit_target = ADDR_BITS'(tgt);
    commit_halt   = halt;
  endtask

  task automatic take_issue();
    issue_t e;
    int     n = 0;
    while (issue_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("issue_valid", 32'(issue_valid), 1);
    check("sb_pending", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("issue_warp", 32'(issue_warp), 32'(e.warp));
      check("issue_pc", 32'(issue_pc), 32'(e.pc));
    end
    issue_ready = 1'b1;
    tick();
  endtask

  task automatic expect_done();
    check("done_pulse", 32'(done), 1);
    check("busy_at_done", 32'(busy), 0);
    check("no_issue_at_done", 32'(issue_valid), 0);
    tick();
    check("done_cleared", 32'(done), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_pc = '0; warp_mask = '0;
    issue_ready = 1'b0; commit_valid = 1'b0; commit_warp = '0;
    commit_branch = 1'b0; commit_nzp = '0; commit_target = '0; commit_halt = 1'b0;
    nzp_we = 1'b0; nzp_warp = '0; nzp_value = '0;
    @(negedge clk);
    do_reset();

    // Reset state.
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_issue_valid", 32'(issue_valid), 0);
    check("rst_issue_warp", 32'(issue_warp), 0);
    check("rst_issue_pc", 32'(issue_pc), 0);

    // Empty launch: done next cycle, never busy.
    launch(8'h33, 4'b0000);
    tick();
    check("empty_done", 32'(done), 1);
    check("empty_busy", 32'(busy), 0);
    tick();
    check("empty_done_clr", 32'(done), 0);
    check("empty_busy_clr", 32'(busy), 0);

    // Basic issue with warps 0 and 2; a commit to a READY warp is ignored.
    do_reset();
    done_base = done_cnt;
    launch(8'h10, 4'b0101);
    expect_issue(0, 8'h10);
    expect_issue(2, 8'h10);
    tick();
    check("basic_busy", 32'(busy), 1);
    set_commit(0, 1'b0, 0, 0, 1'b0);
    tick();
    take_issue();
    take_issue();
    set_commit(0, 1'b0, 0, 0, 1'b0); expect_issue(0, 8'h11); tick();
    set_commit(2, 1'b0, 0, 0, 1'b0); expect_issue(2, 8'h11); tick();
    take_issue();
    take_issue();
    set_commit(0, 1'b0, 0, 0, 1'b1); tick();
    check("basic_busy_one_left", 32'(busy), 1);
    set_commit(2, 1'b0, 0, 0, 1'b1); tick();
    expect_done();
    check("basic_done_count", 32'(done_cnt - done_base), 1);

    // NZP branches on warp 1, including a same-cycle flag write.
    do_reset();
    launch(8'h20, 4'b0010);
    expect_issue(1, 8'h20);
    tick();
    nzp_we = 1'b1; nzp_warp = 2'd1; nzp_value = 3'b010;
    tick();
    take_issue();
    set_commit(1, 1'b1, 3'b011, 8'h40, 1'b0); expect_issue(1, 8'h40); tick();
    take_issue();
    set_commit(1, 1'b1, 3'b100, 8'h60, 1'b0); expect_issue(1, 8'h41); tick();
    take_issue();
    set_commit(1, 1'b1, 3'b010, 8'h80, 1'b0); expect_issue(1, 8'h80);
    nzp_we = 1'b1; nzp_warp = 2'd1; nzp_value = 3'b001;
    tick();
    take_issue();
    set_commit(1, 1'b1, 3'b001, 8'h90, 1'b0); expect_issue(1, 8'h90); tick();
    take_issue();
    // Halt and branch together: halt wins.
    set_commit(1, 1'b1, 3'b001, 8'hA0, 1'b1); tick();
    expect_done();

    // PC wrap.
    do_reset();
    launch(8'hFF, 4'b0001);
    expect_issue(0, 8'hFF);
    tick();
    take_issue();
    set_commit(0, 1'b0, 0, 0, 1'b0); expect_issue(0, 8'h00); tick();
    take_issue();
    set_commit(0, 1'b0, 0, 0, 1'b1); tick();
    expect_done();

    // Four warps: back-pressure, overlapping issue/commit, ignored start, completion.
    do_reset();
    done_base = done_cnt;
    launch(8'h30, 4'b1111);
    for (int w = 0; w < NUM_WARPS; w++) expect_issue(w, 8'h30);
    tick();
    for (int w = 0; w < NUM_WARPS; w++) take_issue();
    set_commit(2, 1'b0, 0, 0, 1'b0); expect_issue(2, 8'h31); tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        set_commit(0, 1'b0, 0, 0, 1'b0);
        expect_issue(0, 8'h31);
      end
      tick();
      check("bp_valid", 32'(issue_valid), 1);
      check("bp_warp", 32'(issue_warp), 2);
      check("bp_pc", 32'(issue_pc), 8'h31);
    end
    set_commit(1, 1'b0, 0, 0, 1'b0); expect_issue(1, 8'h31);
    take_issue();
    take_issue();
    take_issue();
    launch(8'h00, 4'b0001);
    tick();
    check("midrun_start_busy", 32'(busy), 1);
    check("midrun_start_no_issue", 32'(issue_valid), 0);
    for (int w = 0; w < NUM_WARPS; w++) begin
      set_commit(w, 1'b0, 0, 0, 1'b1);
      tick();
      if (w < NUM_WARPS - 1) begin
        check("halt_partial_done", 32'(done), 0);
        check("halt_partial_busy", 32'(busy), 1);
      end
    end
    expect_done();
    tick();
    tick();
    check("four_done_count", 32'(done_cnt - done_base), 1);

    // Reset mid-run, then stray commits to warps that are not waiting.
    do_reset();
    done_base = done_cnt;
    launch(8'h50, 4'b1111);
    expect_issue(0, 8'h50);
    tick();
    take_issue();
    set_commit(0, 1'b0, 0, 0, 1'b0);
    reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_issue_valid", 32'(issue_valid), 0);
    check("midrst_issue_warp", 32'(issue_warp), 0);
    check("midrst_issue_pc", 32'(issue_pc), 0);
    reset = 1'b0;
    tick();
    check("postrst_issue_valid", 32'(issue_valid), 0);
    check("postrst_done", 32'(done), 0);
    set_commit(1, 1'b0, 0, 0, 1'b0);
    tick();
    check("stray_issue_valid", 32'(issue_valid), 0);
    check("stray_busy", 32'(busy), 0);
    set_commit(2, 1'b0, 0, 0, 1'b1);
    tick();
    tick();
    check("stray_halt_no_done", 32'(done_cnt - done_base), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_pc_sequencer.md
# warp_pc_sequencer

Multi-warp successor to the block's single shared program counter: holds one PC, one NZP flag register and one execution state per warp, selects a ready warp round-robin for fetch, and updates its PC on instruction commit. Handles sequential advance, conditional NZP branches, halt, and whole-block completion. Sits between the block dispatcher (start/done) and the fetch/decode/execute pipeline (issue/commit).

## Interface
- `ADDR_BITS`, default 8: program memory address width.
- `NUM_WARPS`, default 4: warp contexts, at least 2.
- `WARP_BITS`, default `$clog2(NUM_WARPS)`: warp index width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle pulse; launches the warps selected by `warp_mask`.
- `start_pc`  in  ADDR_BITS  initial PC for every launched warp.
- `warp_mask`  in  NUM_WARPS  warps taking part in this launch.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when all launched warps have halted.
- `issue_valid`  out  1  a warp is offered for fetch.
- `issue_warp`  out  WARP_BITS  offered warp index.
- `issue_pc`  out  ADDR_BITS  PC of the offered warp.
- `issue_ready`  in  1  fetch accepts the offer.
- `commit_valid`  in  1  an instruction of `commit_warp` retires.
- `commit_warp`  in  WARP_BITS  retiring warp.
- `commit_branch`  in  1  the retiring instruction is BRnzp.
- `commit_nzp`  in  3  branch condition mask, bit order {N,Z,P}.
- `commit_target`  in  ADDR_BITS  branch target.
- `commit_halt`  in  1  the retiring instruction is RET.
- `nzp_we`  in  1  write the NZP register of `nzp_warp`.
- `nzp_warp`  in  WARP_BITS  warp index for the NZP write.
- `nzp_value`  in  3  new {N,Z,P} value.

## Operation
- Per-warp state is one of IDLE, READY, WAIT or HALTED. After reset every warp is IDLE with PC=0 and NZP=0. All outputs reset to 0.
- On `start`, when `busy` is low: each warp with its mask bit set goes to READY with PC=`start_pc` and NZP=0. Each unmasked warp goes to IDLE. `busy` is set.
- A `start` while `busy` is high is ignored.
- `start` with `warp_mask`=0: `done` pulses on the next cycle and `busy` stays low.
- Issue: a round-robin arbiter picks the first READY warp at or after pointer `rr_ptr`.
  - On the handshake (`issue_valid & issue_ready`), that warp goes to WAIT.
  - `rr_ptr` becomes issued index+1, wrapping from NUM_WARPS-1 to 0.
- Commit to a warp in WAIT:
  - `commit_halt`: the warp goes to HALTED and its PC is unchanged.
  - Otherwise, if `commit_branch` and (`commit_nzp` & NZP[warp]) != 0: PC = `commit_target`.
  - Otherwise: PC = PC+1 modulo 2^ADDR_BITS, so PC 2^ADDR_BITS-1 wraps to 0.
  - The warp returns to READY in every non-halt case.
- A commit to a warp not in WAIT is ignored, with no state change.
- When `commit_halt` and `commit_branch` are both set, halt wins.
- NZP write: sets NZP[`nzp_warp`] regardless of warp state.
- A commit and an NZP write to the same warp in the same cycle: the branch decision uses the old NZP value, and the new value is stored.
- Done: the cycle in which the last launched warp reaches HALTED is followed by one cycle of `done`=1 and `busy`=0. All warps then return to IDLE.

## Timing
- `issue_valid`, `issue_warp` and `issue_pc` are combinational from registered state only. There is no combinational path from `issue_ready` or any commit input.
- `issue_valid`, `issue_warp` and `issue_pc` hold stable while `issue_valid`=1 and `issue_ready`=0.
- An issue handshake for one warp and a commit for another warp in the same cycle are both honoured.
- A warp that commits in cycle t is issuable again in cycle t+1.
- Minimum per-warp loop is 2 cycles: issue in t, commit in t+1, reissue in t+2.
- `reset` asserted mid-operation returns every register to its reset value on the next edge, including `busy`=0 and no `done` pulse.

## Structure
- Package `pc_pkg` holds:
  - `warp_state_e` enum (IDLE, READY, WAIT, HALTED);
  - the NZP bit index localparams N=2, Z=1, P=0.
- Sub-module `rr_arbiter` (parameter N) takes a request vector and the `rr_ptr` pointer, and returns a grant-valid bit and the grant index.
- The per-warp PC, NZP and state arrays live in the top module.

## Test plan
- Basic issue: `start` with start_pc=0x10 and mask=4'b0101 → issues alternate warp0 and warp2 at PC 0x10. After commits, the next issues are at 0x11 for each warp.
- Branch on condition: NZP[1]=3'b010, then a commit with branch=1, nzp=3'b011 and target=0x40 → next issue of warp1 has PC 0x40. The same commit with nzp=3'b100 → PC+1.
- Wrap: a warp at PC 0xFF commits a non-branch → next issue has PC 0x00.
- Completion: 4 warps, each commits `commit_halt` → exactly one `done` pulse after the last halt, then `busy`=0. A `start` received mid-run is ignored.
- Back-pressure and same-cycle events: hold `issue_ready`=0 for 3 cycles → the issue outputs stay stable. In the same cycle, commit to and NZP-write the same warp → the branch uses the old NZP value.
- Reset mid-run → next cycle all outputs are 0 and all warps are IDLE. A stray commit with no warp in WAIT → no effect.
